// File: rtl/ipc_mailbox_multi.sv
// ipc_mailbox_multi: host <-> remote mailbox, NUM_CH channels, FIFO per direction.
// Build option IPC_MBOX_IRQ_EN adds IRQ_EN registers and the interrupt outputs.
module ipc_mailbox_multi #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [$clog2(NUM_CH)+1:0] host_address,
  input  logic                      host_read,
  input  logic                      host_write,
  input  logic [31:0]               host_writedata,
  output logic [31:0]               host_readdata,
  input  logic [$clog2(NUM_CH)+1:0] remote_address,
  input  logic                      remote_read,
  input  logic                      remote_write,
  input  logic [31:0]               remote_writedata,
  output logic [31:0]               remote_readdata,
  output logic                      host_irq,
  output logic [NUM_CH-1:0]         remote_irq
);

  localparam int AW = $clog2(NUM_CH) + 2;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int NW = PW + 1;

  // index 0 is the host side, 1 the remote side.
  // FIFO d is pushed by side d and popped by side 1-d.
  logic [1:0][AW-1:0] addr;
  logic [1:0][31:0]   wdata;
  logic [1:0]         rd_raw;
  logic [1:0]         wr_raw;
  logic [1:0]         rd_en;
  logic [1:0]         wr_en;
  logic [1:0][CW-1:0] ch;
  logic [1:0][CW-1:0] ch_ix;
  logic [1:0][1:0]    off;
  logic [1:0]         ch_ok;

  assign addr   = {remote_address, host_address};
  assign wdata  = {remote_writedata, host_writedata};
  assign rd_raw = {remote_read, host_read};
  assign wr_raw = {remote_write, host_write};

  logic [DATA_W-1:0] mem [2][NUM_CH][DEPTH];
  logic [PW-1:0]     wp  [2][NUM_CH];
  logic [PW-1:0]     rp  [2][NUM_CH];
  logic [NW-1:0]     cnt [2][NUM_CH];

  logic [1:0][NUM_CH-1:0] sel;
  logic [1:0][NUM_CH-1:0] empty;
  logic [1:0][NUM_CH-1:0] full;
  logic [1:0][NUM_CH-1:0] push;
  logic [1:0][NUM_CH-1:0] pop;
  logic [1:0][NUM_CH-1:0] flush;
  logic [1:0][NUM_CH-1:0] push_ok;
  logic [1:0][NUM_CH-1:0] pop_ok;

  logic [1:0][NUM_CH-1:0] ovf;
  logic [1:0][NUM_CH-1:0] unf;
  logic [1:0][31:0]       rd_val;

`ifdef IPC_MBOX_IRQ_EN
  logic [1:0][NUM_CH-1:0] irq_en;
`endif

  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // address decode; a read and write on the same cycle is dropped
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      rd_en[s] = rd_raw[s] & ~wr_raw[s];
      wr_en[s] = wr_raw[s] & ~rd_raw[s];
      ch[s]    = CW'(addr[s] >> 2);
      off[s]   = addr[s][1:0];
      ch_ok[s] = (32'(ch[s]) < NUM_CH);
      ch_ix[s] = ch_ok[s] ? ch[s] : '0;
      for (int c = 0; c < NUM_CH; c++)
        sel[s][c] = ch_ok[s] & (ch[s] == CW'(c));
    end
  end

  // per-FIFO push / pop / flush qualification
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        empty[d][c]   = (cnt[d][c] == '0);
        full[d][c]    = (cnt[d][c] == NW'(DEPTH));
        push[d][c]    = wr_en[d] & sel[d][c]
                      & (off[d] == 2'd0);
        pop[d][c]     = rd_en[1-d] & sel[1-d][c]
                      & (off[1-d] == 2'd0);
        flush[d][c]   = wr_en[1-d] & sel[1-d][c]
                      & (off[1-d] == 2'd3)
                      & wdata[1-d][2];
        pop_ok[d][c]  = pop[d][c] & ~empty[d][c];
        push_ok[d][c] = push[d][c] & ~flush[d][c]
                      & (~full[d][c] | pop_ok[d][c]);
      end
    end
  end

  // FIFO storage; contents past the read pointer are don't-care
  always_ff @(posedge clk_clk) begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NUM_CH; c++)
        if (push_ok[d][c])
          mem[d][c][wp[d][c]] <= wdata[d][DATA_W-1:0];
  end

  // FIFO pointers and occupancy; flush beats a racing push
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NUM_CH; c++) begin
          wp[d][c]  <= '0;
          rp[d][c]  <= '0;
          cnt[d][c] <= '0;
        end
    end else begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NUM_CH; c++) begin
          if (flush[d][c]) begin
            wp[d][c]  <= '0;
            rp[d][c]  <= '0;
            cnt[d][c] <= '0;
          end else begin
            if (push_ok[d][c])
              wp[d][c] <= wp[d][c] + PW'(1);
            if (pop_ok[d][c])
              rp[d][c] <= rp[d][c] + PW'(1);
            cnt[d][c] <= cnt[d][c]
                       + NW'(push_ok[d][c])
                       - NW'(pop_ok[d][c]);
          end
        end
    end
  end

  // sticky overflow (own pushes) and underflow (own pops) per side
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ovf <= '0;
      unf <= '0;
    end else begin
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < NUM_CH; c++) begin
          if (push[s][c] & ~flush[s][c]
              & full[s][c] & ~pop_ok[s][c])
            ovf[s][c] <= 1'b1;
          else if (wr_en[s] & sel[s][c]
                   & (off[s] == 2'd3) & wdata[s][0])
            ovf[s][c] <= 1'b0;
          if (pop[1-s][c] & empty[1-s][c])
            unf[s][c] <= 1'b1;
          else if (wr_en[s] & sel[s][c]
                   & (off[s] == 2'd3) & wdata[s][1])
            unf[s][c] <= 1'b0;
        end
    end
  end

  // read mux: DATA head, STATUS, IRQ_EN; CLEAR and unmapped read 0
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      rd_val[s] = '0;
      if (ch_ok[s]) begin
        unique case (1'b1)
          off[s] == 2'd0: begin
            if (!empty[1-s][ch_ix[s]])
              rd_val[s] = 32'(mem[1-s][ch_ix[s]][rp[1-s][ch_ix[s]]]);
          end
          off[s] == 2'd1: begin
            rd_val[s][0]       = ~empty[1-s][ch_ix[s]];
            rd_val[s][1]       = full[s][ch_ix[s]];
            rd_val[s][2]       = ovf[s][ch_ix[s]];
            rd_val[s][3]       = unf[s][ch_ix[s]];
            rd_val[s][8 +: NW] = cnt[1-s][ch_ix[s]];
          end
          off[s] == 2'd2: begin
`ifdef IPC_MBOX_IRQ_EN
            rd_val[s][0] = irq_en[s][ch_ix[s]];
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // readdata is captured on a legal read and held otherwise
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      host_readdata   <= '0;
      remote_readdata <= '0;
    end else begin
      if (rd_en[0])
        host_readdata <= rd_val[0];
      if (rd_en[1])
        remote_readdata <= rd_val[1];
    end
  end

`ifdef IPC_MBOX_IRQ_EN
  // IRQ_EN registers, one per side per channel
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_en <= '0;
    end else begin
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < NUM_CH; c++)
          if (wr_en[s] & sel[s][c] & (off[s] == 2'd2))
            irq_en[s][c] <= wdata[s][0];
    end
  end

  // level interrupts, registered from current occupancy
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      host_irq   <= 1'b0;
      remote_irq <= '0;
    end else begin
      host_irq   <= |(irq_en[0] & ~empty[1]);
      remote_irq <= irq_en[1] & ~empty[0];
    end
  end
`else
  assign host_irq   = 1'b0;
  assign remote_irq = '0;
`endif

endmodule

// File: doc/ipc_mailbox_multi.md
# ipc_mailbox_multi

Parametrised inter-processor mailbox between the HPS (host) and up to eight Nios II cores (remote). Each of NUM_CH channels has a host-to-remote FIFO and a remote-to-host FIFO of DEPTH words, sticky overflow flags and maskable interrupts. Both sides reach it through fixed-latency Avalon-MM slaves on the shared fabric clock. It replaces single-bit PIO handshaking between the processors.

## Interface
- NUM_CH, 2, channel count, 1..8
- DATA_W, 32, mailbox word width, 8..32
- DEPTH, 4, FIFO depth per direction per channel, power of two, 2..64
- clk_clk  in  1  fabric clock; single clock domain
- reset_reset_n  in  1  asynchronous, active-low reset
- host_address  in  clog2(NUM_CH)+2  {channel, register offset}
- host_read  in  1  read strobe
- host_write  in  1  write strobe
- host_writedata  in  32  write data
- host_readdata  out  32  read data, one-cycle latency
- remote_address  in  clog2(NUM_CH)+2  same layout as host side
- remote_read / remote_write  in  1  strobes
- remote_writedata  in  32  write data
- remote_readdata  out  32  read data, one-cycle latency
- host_irq  out  1  OR of all enabled host-side channel interrupts
- remote_irq  out  NUM_CH  one interrupt per channel, one bit per Nios

## Operation
- Register offsets, per channel, identical on both sides. "In" is the FIFO this side pops; "out" is the FIFO it pushes.
  - 0 DATA: write pushes writedata[DATA_W-1:0] into out. Read pops in and returns the head, zero-extended.
  - 1 STATUS, read-only: bit0 in non-empty, bit1 out full, bit2 overflow sticky, bit3 underflow sticky, [14:8] in count.
  - 2 IRQ_EN, R/W: bit0 enables the irq on in non-empty.
  - 3 CLEAR, write-only, reads 0: bit0 clears overflow, bit1 clears underflow, bit2 flushes in.
- Push to a full FIFO with no pop on the same cycle: word dropped, overflow set on the writing side.
- Pop of an empty FIFO: returns 0, no state change except underflow set on the reading side.
- Push and pop of the same FIFO on the same cycle:
  - Both take effect and count is unchanged.
  - A push into a full FIFO succeeds when a pop happens on the same cycle.
- Flush racing a push: the flush wins and the pushed word is discarded.
- A simultaneous read and write strobe on one side is illegal and ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits and saturates neither way.
- Interrupts:
  - remote_irq[c] = IRQ_EN(remote,c) AND host-to-remote FIFO of c non-empty.
  - host_irq = OR over c of IRQ_EN(host,c) AND remote-to-host FIFO of c non-empty.
  - Level-sensitive; an irq clears by draining the FIFO or by clearing its IRQ_EN.

## Timing
- Reset values:
  - All FIFOs empty; all sticky flags 0; IRQ_EN 0.
  - host_readdata, remote_readdata, host_irq and remote_irq all 0.
- Read latency is exactly 1. readdata is registered and valid the cycle after the read strobe, then held until the next read.
- Writes commit at the clock edge of the strobe cycle. STATUS reads issued on the following cycle reflect the write.
- Interrupts are registered and assert one cycle after the FIFO becomes non-empty with its enable set. They deassert one cycle after the last pop.
- Data is visible to the opposite side's read one cycle after the push.
- Reset asserted mid-transfer loses all FIFO contents immediately. No partial word survives.

## Configuration
- IPC_MBOX_IRQ_EN
  - Defined: interrupt logic and IRQ_EN registers as above.
  - Undefined: IRQ_EN reads 0 and ignores writes, and host_irq and remote_irq are tied 0. Software polls STATUS only.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then read STATUS of every channel on both sides -> 0x0000_0000; irqs 0.
- Host writes 0xA5A5_0001..0xA5A5_0004 to ch1 DATA (DEPTH=4) -> host STATUS.bit1=1; remote STATUS = 0x0000_0401. A fifth write sets host overflow (STATUS=0x6) and is dropped. Remote then reads four words in order.
- Remote IRQ_EN ch0=1, host pushes 0x1234 -> remote_irq[0] rises 1 cycle later. Remote read returns 0x1234 and remote_irq[0] falls 1 cycle after the pop.
- With FIFO full, a same-cycle host push of 0x55 and remote pop -> count stays 4, no overflow, and 0x55 is read last.
- Remote reads empty ch2 -> readdata 0, remote STATUS bit3=1. Writing CLEAR=0x2 clears it.
- Build without IPC_MBOX_IRQ_EN: write IRQ_EN=1 and push data -> IRQ_EN reads 0, host_irq and remote_irq stay 0.
